load_store_unit: RTL
====================

# load_store_unit

Memory-stage controller between the pipeline's EX/MEM register and the word-only `DataMemory`. It turns MIPS32 load/store requests (LB, LBU, LH, LHU, LW, SB, SH, SW) into word accesses on the memory port. Sub-word loads are sign- or zero-extended. Sub-word stores are done as read-modify-write, because `DataMemory` writes full words only. The pipeline stalls while `busy` is high; alignment and range errors are flagged instead of reaching memory.

## Interface

- `MEM_WORDS`, default 4096: number of 32-bit words in `DataMemory`. Byte addresses at or above `MEM_WORDS*4` are out of range.

- `clk`  in  1: single clock. Memory reads on the rising edge and writes on the falling edge.
- `reset`  in  1: asynchronous, active-high.
- `req`  in  1: request valid. Sampled only in IDLE.
- `is_store`  in  1: 1 = store, 0 = load.
- `size`  in  2: 00 byte, 01 half, 10 word, 11 illegal.
- `uns`  in  1: zero-extend sub-word loads (LBU/LHU). Ignored for stores and words.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data. Byte/half data is taken from the low bits.
- `busy`  out  1: unit is occupied (state ≠ IDLE).
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: valid with `done`. Misaligned, illegal size, or out of range.
- `rdata`  out  32: extended load result. Valid from `done` and held until the next load's `done`.
- `MemRead`, `MemWrite`  out  1: to `DataMemory`.
- `Address`  out  32: `{addr_q[31:2],2'b00}`.
- `WriteData`  out  32: to `DataMemory`.
- `ReadData`  in  32: from `DataMemory`. Registered by memory on the rising edge when `MemRead`=1.

## Operation

- **Request capture.** On a rising edge in IDLE with `req`=1, latch `addr`, `size`, `uns`, `is_store`, `wdata` into `_q` registers.
- **Error check at capture.** An error is any of:
  - `size`=11;
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - `addr` ≥ `MEM_WORDS*4`.
- **States and transitions:**
  - IDLE → RESP when the request has an error. No memory strobe; `err`=1.
  - IDLE → WR for SW.
  - IDLE → RD for any load, SB, or SH.
  - RD: `MemRead`=1 → EXT.
  - EXT: for loads, `rdata` ← extracted word → RESP. For SB/SH, `wbuf` ← merged word → WR.
  - WR: `MemWrite`=1, `WriteData` = `wdata_q` (SW) or `wbuf` (SB/SH) → RESP.
  - RESP: `done`=1 → IDLE.
- **Byte lanes (little-endian).** Byte k occupies bits [8k+7:8k], with k = `addr_q[1:0]`. The halfword at `addr_q[1]`=0 is bits 15:0; at `addr_q[1]`=1 it is bits 31:16.
- **Load extension.** The extracted byte or half is sign-extended when `uns_q`=0 and zero-extended when `uns_q`=1. Words pass through unchanged.
- **Store merge.** `ReadData` with the selected lane(s) replaced by `wdata_q[7:0]` or `wdata_q[15:0]`. All other bits are preserved.
- **Output rules.**
  - `MemRead` and `MemWrite` are never high together.
  - Each is high for exactly one cycle per access.
  - `Address` is driven to the latched aligned address in RD and WR, and to 0 otherwise.
- `rdata` is unchanged by stores and by erroring requests.

## Timing

- **Reset values.** `busy`, `done`, `err`, `MemRead`, `MemWrite` = 0; `Address`, `WriteData`, `rdata`, `wbuf` = 0. State returns to IDLE immediately (asynchronous).
- **Latency.** Counted in rising edges from the capture edge to `done` high:

  | Operation | Path | `done` high after |
  |---|---|---|
  | SW | WR, RESP | 2 edges |
  | LB/LBU/LH/LHU/LW | RD, EXT, RESP | 3 edges |
  | SB/SH | RD, EXT, WR, RESP | 4 edges |
  | Error | RESP | 1 edge |

- `busy` rises on the capture edge and falls on the edge that leaves RESP.
- **Back-to-back requests.** A request can be accepted on the edge that leaves RESP? No: it is accepted on the first edge where state = IDLE. `req` high while `busy` is ignored; the pipeline must hold `req` and operands.
- **Write visibility.** The memory write happens on the falling edge inside WR. A load issued after `done` observes the new data.
- **Reset mid-operation:**
  - Reset in RD or EXT: no write occurs.
  - Reset in WR before the falling edge: no write occurs.
  - Reset after the falling edge: the write stands.
  - No `done` pulse is produced for an aborted request.

## Test plan

- **Reset values.** Assert `reset` → all outputs 0 and `busy`=0. Release → IDLE.
- **SW then LW.** SW `addr`=0x10, `wdata`=0xDEADBEEF: `MemWrite` pulses once and `done` arrives 2 edges after capture. Then LW 0x10 → `rdata`=0xDEADBEEF, `err`=0, with `done` 3 edges after capture.
- **Byte store and sign handling.** Starting from word 0x10 = 0xDEADBEEF:
  - SB `addr`=0x11, `wdata`=0x00000080 → word becomes 0xDEAD80EF.
  - LB 0x11 → `rdata`=0xFFFFFF80.
  - LBU 0x11 → 0x00000080.
- **Halfword store and extension.** SH `addr`=0x12, `wdata`=0x1234 → word becomes 0x123480EF. LH 0x12 → 0x00001234. LHU 0x10 → 0x000080EF. LH 0x10 → 0xFFFF80EF.
- **Error cases.** Each of the following gives `done`=1 and `err`=1 one edge after capture, with no `MemRead`/`MemWrite` pulse and `rdata` unchanged:
  - LW 0x12 (misaligned word);
  - SH 0x13 (misaligned half);
  - `size`=11;
  - LW 0x4000 (out of range).
- **Reset mid-RMW and held request.**
  - SB 0x20 with `reset` pulsed during EXT → memory word at 0x20 unchanged and no `done`.
  - `req` held high while `busy` → exactly one access is performed per acceptance.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-stage controller that turns MIPS32 byte/half/word
//            loads and stores into full-word accesses on a word-only data
//            memory. Sub-word loads are sign/zero extended. Sub-word stores
//            are done as read-modify-write. Errors (illegal size, misaligned
//            or out-of-range address) never reach memory.
// Ports    : clk, reset (async, active-high)
//            req/is_store/size/uns/addr/wdata : request from the pipeline
//            busy/done/err/rdata              : status and load result
//            MemRead/MemWrite/Address/WriteData/ReadData : DataMemory port
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EXT  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [1:0]  SZ_BYTE    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_WORD    = 2'b10;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS * 4);

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q, wbuf;
    logic [1:0]  size_q;
    logic        uns_q, is_store_q, err_q;

    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, merged;

    // Request-side error detection, evaluated on the inputs at capture.
    assign req_err = (size == 2'b11)
                   | ((size == SZ_HALF) & addr[0])
                   | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
                   | ({1'b0, addr} >= ADDR_LIMIT);

    // Lane extraction/merge on the word returned by memory (valid in EXT).
    always_comb begin
        byte_sel = ReadData[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? ReadData[31:16] : ReadData[15:0];

        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = ReadData;
        endcase

        merged = ReadData;
        if (size_q == SZ_BYTE) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (size_q == SZ_HALF) begin
            if (addr_q[1]) merged[31:16] = wdata_q[15:0];
            else           merged[15:0]  = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        err        = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = 32'd0;
        WriteData  = 32'd0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (req_err)                             state_next = S_RESP;
                    else if (is_store && (size == SZ_WORD))  state_next = S_WR;
                    else                                     state_next = S_RD;
                end
            end
            S_RD: begin
                MemRead    = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                state_next = S_EXT;
            end
            S_EXT: begin
                state_next = is_store_q ? S_WR : S_RESP;
            end
            S_WR: begin
                MemWrite   = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                WriteData  = (size_q == SZ_WORD) ? wdata_q : wbuf;
                state_next = S_RESP;
            end
            S_RESP: begin
                done       = 1'b1;
                err        = err_q;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            wbuf       <= 32'd0;
            rdata      <= 32'd0;
        end else begin
            if ((state == S_IDLE) && req) begin
                addr_q     <= addr;
                wdata_q    <= wdata;
                size_q     <= size;
                uns_q      <= uns;
                is_store_q <= is_store;
                err_q      <= req_err;
            end
            if (state == S_EXT) begin
                if (is_store_q) wbuf  <= merged;
                else            rdata <= load_val;
            end
        end
    end

endmodule
`default_nettype wire
